// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared UART receiver state encoding and baud divider helper
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Integer truncation: the bit period is always slightly short, never long.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/serial_rx_fifo_if.sv
// rtl/serial_rx_fifo_if.sv - received byte stream and line status from rx front-end to parser
interface serial_rx_fifo_if #(
    parameter int DBUS_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
);
    logic [DBUS_WIDTH-1:0]       rx_data;
    logic                        rx_valid;
    logic                        rx_ready;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        frame_err;
    logic                        overrun;
    logic                        parity_err;

    modport master (
        output rx_data, rx_valid, fifo_count, frame_err, overrun, parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, fifo_count, frame_err, overrun, parity_err,
        output rx_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO; head reads as zero while empty
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/serial_rx_fifo.sv
// rtl/serial_rx_fifo.sv - UART rx: rxd synchroniser, 8N1 deframer, FWFT byte queue.
// Define RX_PARITY_EN to expect an even parity bit between data and stop.
module serial_rx_fifo
    import serial_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int BAUD          = 115_200,
    parameter int DBUS_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rxd,
    serial_rx_fifo_if.master  rx
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQUENCY, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = (DBUS_WIDTH > 1) ? $clog2(DBUS_WIDTH) : 1;

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DBUS_WIDTH - 1);

    logic                  sync_meta;
    logic                  rxd_s;
    rx_state_t             state;
    logic [CNT_W-1:0]      baud_cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [DBUS_WIDTH-1:0] shift;
    logic                  push;
    logic                  frame_err_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  bit_done;
`ifdef RX_PARITY_EN
    logic                  parity_bad;
    logic                  parity_err_q;
`endif

    // Preset to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b1;
            rxd_s     <= 1'b1;
        end else begin
            sync_meta <= rxd;
            rxd_s     <= sync_meta;
        end
    end

    assign bit_done = (baud_cnt == BIT_END);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            push         <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef RX_PARITY_EN
            parity_bad   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            push        <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            baud_cnt    <= baud_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (!rxd_s) state <= ST_START;
                end
                ST_START: begin
                    if (baud_cnt == HALF_END) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rxd_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        shift    <= {rxd_s, shift[DBUS_WIDTH-1:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
`ifdef RX_PARITY_EN
                            state   <= ST_PARITY;
`else
                            state   <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        baud_cnt   <= '0;
                        parity_bad <= rxd_s ^ (^shift);
                        state      <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (rxd_s) begin
                            state <= ST_IDLE;
`ifdef RX_PARITY_EN
                            push         <= ~parity_bad;
                            parity_err_q <= parity_bad;
`else
                            push         <= 1'b1;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    baud_cnt <= '0;
                    if (rxd_s) state <= ST_IDLE;
                end
                default: begin
                    baud_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DBUS_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (shift),
        .pop       (rx.rx_ready),
        .pop_data  (rx.rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx.fifo_count)
    );

    assign rx.rx_valid  = ~fifo_empty;
    assign rx.frame_err = frame_err_q;
    assign rx.overrun   = push & fifo_full & ~rx.rx_ready;
`ifdef RX_PARITY_EN
    assign rx.parity_err = parity_err_q;
`else
    assign rx.parity_err = 1'b0;
`endif

endmodule
